// File: rtl/fifo_bh_multi_depth.sv
//------------------------------------------------------------------------------
// Module   : fifo_bh_multi_depth
// Brief    : Parametrised-depth FWFT synchronous FIFO with level, almost-full/
//            almost-empty status and sticky overflow/underflow flags
//            (flags built only when FIFO_BH_ERR_FLAGS_EN is defined).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_bh_multi_depth #(
   parameter int FIFO_DATA_WIDTH = 986,
   parameter int FIFO_DEPTH      = 4,
   parameter int AFULL_THRESH    = 3,
   parameter int AEMPTY_THRESH   = 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  wren_i,
   input  logic                                  rden_i,
   input  logic [FIFO_DATA_WIDTH-1:0]            wdata_i,
   output logic [FIFO_DATA_WIDTH-1:0]            rdata_o,
   output logic                                  full_o,
   output logic                                  empty_o,
   output logic                                  almost_full_o,
   output logic                                  almost_empty_o,
   output logic [$clog2(FIFO_DEPTH):0]           count_o,
   output logic                                  overflow_o,
   output logic                                  underflow_o
);

   localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
   localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

   localparam logic [CNT_WIDTH-1:0] DEPTH_CNT  = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] AFULL_CNT  = CNT_WIDTH'(AFULL_THRESH);
   localparam logic [CNT_WIDTH-1:0] AEMPTY_CNT = CNT_WIDTH'(AEMPTY_THRESH);

   logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [CNT_WIDTH-1:0]       wr_ptr;
   logic [CNT_WIDTH-1:0]       rd_ptr;
   logic [CNT_WIDTH-1:0]       count;
   logic                       rd_acc;
   logic                       wr_acc;

   // Extra pointer bit distinguishes full from empty when addresses match.
   assign count          = wr_ptr - rd_ptr;
   assign empty_o        = (count == '0);
   assign full_o         = (count == DEPTH_CNT);
   assign almost_full_o  = (count >= AFULL_CNT);
   assign almost_empty_o = (count <= AEMPTY_CNT);
   assign count_o        = count;

   // A full FIFO still takes a write when the same edge frees the head slot.
   assign rd_acc = rden_i & ~empty_o;
   assign wr_acc = wren_i & (~full_o | rd_acc);

   assign rdata_o = mem[rd_ptr[ADDR_WIDTH-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_acc) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdata_i;
      end
   end

`ifdef FIFO_BH_ERR_FLAGS_EN
   logic overflow_flag;
   logic underflow_flag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_flag  <= 1'b0;
         underflow_flag <= 1'b0;
      end else begin
         if (wren_i & ~wr_acc) begin
            overflow_flag <= 1'b1;
         end
         if (rden_i & empty_o) begin
            underflow_flag <= 1'b1;
         end
      end
   end

   assign overflow_o  = overflow_flag;
   assign underflow_o = underflow_flag;
`else
   assign overflow_o  = 1'b0;
   assign underflow_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_bh_multi_depth.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_bh_multi_depth
// Brief    : Scoreboard bench for fifo_bh_multi_depth against a queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_bh_multi_depth;

   localparam int W   = 986;
   localparam int D   = 4;
   localparam int AF  = 3;
   localparam int AE  = 1;
   localparam int CW  = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wren_i = 1'b0;
   logic          rden_i = 1'b0;
   logic [W-1:0]  wdata_i = '0;
   logic [W-1:0]  rdata_o;
   logic          full_o, empty_o, almost_full_o, almost_empty_o;
   logic [CW-1:0] count_o;
   logic          overflow_o, underflow_o;

   fifo_bh_multi_depth #(
      .FIFO_DATA_WIDTH (W),
      .FIFO_DEPTH      (D),
      .AFULL_THRESH    (AF),
      .AEMPTY_THRESH   (AE)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .wren_i         (wren_i),
      .rden_i         (rden_i),
      .wdata_i        (wdata_i),
      .rdata_o        (rdata_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .count_o        (count_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
   );

   always #5 clk = ~clk;

`ifdef FIFO_BH_ERR_FLAGS_EN
   localparam bit FLAGS_ON = 1'b1;
`else
   localparam bit FLAGS_ON = 1'b0;
`endif

   typedef struct {
      int           cnt;
      logic [W-1:0] head;
      bit           rd;
      bit           ovf;
      bit           unf;
   } rec_t;

   // Behavioural model: contents as a queue plus sticky flag state.
   logic [W-1:0] model_q[$];
   bit           ovf_m;
   bit           unf_m;

   rec_t         recs[$];
   logic [W-1:0] exp_rd[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_data(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got low64 %h expected low64 %h at %0t",
                  name, act[63:0], exp[63:0], $time);
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < W; i += 32) begin
         v = (v << 32) | W'($urandom);
      end
      return v;
   endfunction

   // Issue one cycle of stimulus; expectations for this cycle go to the scoreboard.
   task automatic step(input bit w, input bit r, input logic [W-1:0] d);
      rec_t rec;
      int   cnt;
      bit   racc, wacc;
      wren_i  = w;
      rden_i  = r;
      wdata_i = d;
      cnt  = model_q.size();
      racc = r && (cnt > 0);
      wacc = w && ((cnt < D) || racc);
      rec.cnt  = cnt;
      rec.head = (cnt > 0) ? model_q[0] : '0;
      rec.rd   = racc;
      rec.ovf  = FLAGS_ON & ovf_m;
      rec.unf  = FLAGS_ON & unf_m;
      recs.push_back(rec);
      if (racc) begin
         exp_rd.push_back(model_q[0]);
         void'(model_q.pop_front());
      end
      if (wacc) begin
         model_q.push_back(d);
      end
      if (w && !wacc) ovf_m = 1'b1;
      if (r && cnt == 0) unf_m = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares DUT outputs mid-cycle against the queued expectations.
   rec_t mrec;
   always @(negedge clk) begin
      if (!reset && recs.size() > 0) begin
         mrec = recs.pop_front();
         chk("count", count_o, mrec.cnt);
         chk("empty", empty_o, mrec.cnt == 0);
         chk("full", full_o, mrec.cnt == D);
         chk("almost_full", almost_full_o, mrec.cnt >= AF);
         chk("almost_empty", almost_empty_o, mrec.cnt <= AE);
         chk("overflow", overflow_o, mrec.ovf);
         chk("underflow", underflow_o, mrec.unf);
         if (mrec.cnt > 0) chk_data("head", rdata_o, mrec.head);
         if (mrec.rd) begin
            if (exp_rd.size() == 0) begin
               chk("scoreboard_underrun", 1, 0);
            end else begin
               chk_data("read_word", rdata_o, exp_rd.pop_front());
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_count"}, count_o, 0);
      chk({tag, "_empty"}, empty_o, 1);
      chk({tag, "_full"}, full_o, 0);
      chk({tag, "_almost_empty"}, almost_empty_o, 1);
      chk({tag, "_almost_full"}, almost_full_o, 0);
      chk({tag, "_overflow"}, overflow_o, 0);
      chk({tag, "_underflow"}, underflow_o, 0);
      chk_data({tag, "_rdata"}, rdata_o, '0);
   endtask

   task automatic model_reset();
      model_q.delete();
      recs.delete();
      exp_rd.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
   endtask

   logic [W-1:0] a [4];
   logic [W-1:0] b, c, dw, e;

   initial begin
      model_reset();
      for (int i = 0; i < 4; i++) a[i] = rand_word();
      b  = rand_word();
      c  = rand_word();
      dw = rand_word();
      e  = rand_word();

      // Test 1: reset state
      #2;
      check_reset_state("reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Test 2: fill A1..A4
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, a[i]);
      // Test 3: write on full is dropped
      step(1'b1, 1'b0, b);
      // Test 4: write+read on full, then drain
      step(1'b1, 1'b1, c);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
      // Test 5: write+read on empty
      step(1'b1, 1'b1, dw);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), rand_word());
      end

      // Test 6: reach count 3, then reset between edges
      while (model_q.size() > 0) step(1'b0, 1'b1, '0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_word());
      step(1'b0, 1'b1, '0);
      step(1'b1, 1'b0, rand_word());
      chk("pre_reset_count", count_o, 3);
      wren_i = 1'b0;
      rden_i = 1'b0;
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      check_reset_state("async_reset");
      @(negedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, e);
      step(1'b0, 1'b0, '0);
      step(1'b1, 1'b0, rand_word());
      while (model_q.size() > 0) step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);

      chk("scoreboard_drained", exp_rd.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
